sram_1r1w_ecc: RTL and testbench
================================

SRAM_1R1W_ECC -- requirements
Module: sram_1r1w_ecc

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits (4..64).
REQ-002 SHALL have parameter ADDR_W, default 10, address width; depth = 2**ADDR_W words.
REQ-003 SHALL have parameter CNT_W, default 16, error counter width.
REQ-004 SHALL have port CE  in  1  clock; all logic on its rising edge.
REQ-005 SHALL have port RST  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port CSB1  in  1  read select, active low.
REQ-007 SHALL have port A1  in  ADDR_W  read address.
REQ-008 SHALL have port O1  out  DATA_W  corrected read data.
REQ-009 SHALL have port V1  out  1  O1/SBE1/DBE1 valid strobe, one cycle per read.
REQ-010 SHALL have port SBE1  out  1  single-bit error corrected on this read.
REQ-011 SHALL have port DBE1  out  1  uncorrectable double-bit error on this read.
REQ-012 SHALL have port CSB2  in  1  write select, active low.
REQ-013 SHALL have port WEB2  in  1  write enable, active low.
REQ-014 SHALL have port A2  in  ADDR_W  write address.
REQ-015 SHALL have port I2  in  DATA_W  write data.
REQ-016 SHALL have port INJ2  in  2  error inject: 01 flips codeword bit 0; 11 flips bits 0 and 1; 00/10 none.
REQ-017 SHALL have port SCRUB_EN  in  1  enable write-back of corrected data.
REQ-018 SHALL have port CNT_CLR  in  1  synchronous clear of both error counters.
REQ-019 SHALL have port SBE_CNT  out  CNT_W  saturating count of SBE1 pulses.
REQ-020 SHALL have port DBE_CNT  out  CNT_W  saturating count of DBE1 pulses.

Function
REQ-021 SHALL store per word an extended-Hamming SECDED codeword of DATA_W+P+1 bits, P = smallest integer with 2**P >= DATA_W+P+1 (39 bits for DATA_W=32).
REQ-022 SHALL write encode(I2) XOR inject mask into mem[A2] at the edge where CSB2=0 and WEB2=0.
REQ-023 SHALL, for a read accepted at edge k (CSB1=0), register the raw codeword at edge k and register decoded O1, SBE1, DBE1 with V1=1 at edge k+1 (latency 2, fully pipelined, one read per cycle).
REQ-024 SHALL return pre-write contents when a read and a write (user or scrub) target the same address at the same edge.
REQ-025 SHALL decode: syndrome 0 and parity ok -> clean; parity bad -> SBE, flip indicated bit (syndrome 0 means the overall parity bit itself); syndrome nonzero and parity ok -> DBE, O1 = raw data bits uncorrected.
REQ-026 SHALL hold O1 at its last value and drive V1, SBE1, DBE1 low in cycles with no read completing.
REQ-027 SHALL, when SBE1=1 and SCRUB_EN=1 and no scrub pending, load a single-entry scrub register with {address, corrected data}.
REQ-028 SHALL drop (not overwrite) a new scrub request while one is pending; counters still increment.
REQ-029 SHALL issue the pending scrub as a clean write at the first edge with no user write; user writes always win.
REQ-030 SHALL cancel a pending scrub when a user write to the same address is accepted.
REQ-031 SHALL increment SBE_CNT/DBE_CNT by one per SBE1/DBE1 pulse, saturating at 2**CNT_W-1; CNT_CLR at the same edge as an error wins (counter -> 0).
REQ-032 SHALL treat out-of-range conditions as impossible: depth is exactly 2**ADDR_W, no address checking.

Reset
REQ-033 SHALL on RST clear V1, SBE1, DBE1, O1 (to 0), both counters, the read pipeline and the scrub register.
REQ-034 SHALL not initialise or modify array contents on reset; reads and writes accepted at a reset edge are discarded.

Structure
REQ-035 SHALL place the parity-count function, codeword-width function and syndrome/status typedef in shared package ecc_pkg.
REQ-036 SHALL implement the encoder and the decoder each as a combinational sub-module: ecc_secded_enc and ecc_secded_dec, reused by sibling ECC memories.

Verification
REQ-037 Write 0xDEADBEEF @0x005, read @0x005 -> V1=1 two edges later, O1=0xDEADBEEF, SBE1=DBE1=0.
REQ-038 Write 0x12345678 @0x3FF with INJ2=01, SCRUB_EN=1, read twice -> first O1=0x12345678 SBE1=1, SBE_CNT=1; scrub issued; later read SBE1=0.
REQ-039 Write 0xA5A5A5A5 @0x010 with INJ2=11, read -> DBE1=1, SBE1=0, DBE_CNT=1, no scrub.
REQ-040 Same-edge read and write @0x020 (old 0x1, new 0x2) -> read returns 0x1; next read returns 0x2.
REQ-041 SBE pending @0x030, user write 0x55 @0x030 each cycle then stop -> scrub cancelled, later read 0x55.
REQ-042 Assert RST mid back-to-back reads -> V1 low next edge, counters 0, stored data intact on subsequent read.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared SECDED helpers for the ECC memory family: check-bit count, codeword width,
// and the syndrome/status types produced by the decoder.
// Codeword layout: bit 0 is the overall parity bit. Bits 1..N-1 are classic Hamming
// positions: powers of two carry check bits, and the rest carry data LSB-first.
package ecc_pkg;

    // Wide enough for a syndrome of a 64-bit word (7 check bits).
    localparam int ECC_SYN_W = 7;

    typedef logic [ECC_SYN_W-1:0] ecc_syn_t;

    typedef enum logic [1:0] {
        ECC_CLEAN = 2'd0,
        ECC_SBE   = 2'd1,
        ECC_DBE   = 2'd2
    } ecc_status_e;

    // Smallest P with 2**P >= data_w + P + 1.
    function automatic int ecc_parity_bits(input int data_w);
        int p;
        p = 1;
        while ((2 ** p) < (data_w + p + 1)) begin
            p = p + 1;
        end
        return p;
    endfunction

    // Data bits plus Hamming check bits plus the overall parity bit.
    function automatic int ecc_cw_width(input int data_w);
        return data_w + ecc_parity_bits(data_w) + 1;
    endfunction

endpackage

// File: rtl/ecc_secded_dec.sv
// Extended-Hamming SECDED decoder: codeword -> corrected data plus clean/SBE/DBE status.
// Latency: combinational.
// Backpressure: none, pure function of the input.
// Ports: cw in, data (DATA_W) out, status (ecc_status_e) out.
module ecc_secded_dec
    import ecc_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [ecc_cw_width(DATA_W)-1:0] cw,
    output logic [DATA_W-1:0]               data,
    output ecc_status_e                     status
);

    localparam int CW_W = ecc_cw_width(DATA_W);

    logic [CW_W-1:0] fixed;
    ecc_syn_t        syn;
    logic            parity_bad;

    always_comb begin
        syn = '0;
        // The syndrome is the XOR of the positions of all set bits.
        for (int i = 1; i < CW_W; i++) begin
            if (cw[i]) begin
                syn = syn ^ ecc_syn_t'(i);
            end
        end
        parity_bad = ^cw;
        fixed      = cw;
        status     = ECC_CLEAN;
        if (parity_bad) begin
            // Odd error count: treat as a single flip at the syndrome position.
            // Syndrome 0 points at the overall parity bit itself.
            status = ECC_SBE;
            for (int i = 0; i < CW_W; i++) begin
                if (ecc_syn_t'(i) == syn) begin
                    fixed[i] = ~cw[i];
                end
            end
        end else if (syn != '0) begin
            // Even error count with a nonzero syndrome: uncorrectable. Pass raw data through.
            status = ECC_DBE;
        end
    end

    for (genvar p = 1; p < CW_W; p++) begin : g_pos
        if ((p & (p - 1)) != 0) begin : g_data
            assign data[p - 1 - $clog2(p + 1)] = fixed[p];
        end
    end

endmodule

// File: rtl/ecc_secded_enc.sv
// Extended-Hamming SECDED encoder: data word -> codeword (layout as in ecc_pkg).
// Latency: combinational.
// Backpressure: none, pure function of the input.
// Ports: data (DATA_W) in, cw (DATA_W+P+1) out.
module ecc_secded_enc
    import ecc_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]               data,
    output logic [ecc_cw_width(DATA_W)-1:0] cw
);

    localparam int CW_W = ecc_cw_width(DATA_W);
    localparam int P    = ecc_parity_bits(DATA_W);

    // Data bits scattered onto non-power-of-two positions; check positions are zero.
    logic [CW_W-1:0] placed;

    for (genvar p = 0; p < CW_W; p++) begin : g_pos
        if ((p > 0) && ((p & (p - 1)) != 0)) begin : g_data
            // The index is the number of non-power-of-two positions below p.
            assign placed[p] = data[p - 1 - $clog2(p + 1)];
        end else begin : g_chk
            assign placed[p] = 1'b0;
        end
    end

    always_comb begin
        logic [CW_W-1:0] c;
        c = placed;
        for (int j = 0; j < P; j++) begin
            for (int i = 1; i < CW_W; i++) begin
                if (((i >> j) & 1) != 0) begin
                    c[1 << j] = c[1 << j] ^ placed[i];
                end
            end
        end
        // The overall parity bit makes the total codeword parity even.
        c[0] = ^c[CW_W-1:1];
        cw = c;
    end

endmodule

// File: rtl/sram_1r1w_ecc.sv
// 1R1W SECDED-protected SRAM with error injection, scrub write-back and error counters.
// Latency: the read is accepted at edge k and O1/V1/SBE1/DBE1 are registered at edge k+1; one read per cycle.
// Backpressure: none. Reads and writes are always accepted, and user writes pre-empt the scrub write-back.
// Ports: CE/RST clock and sync reset; CSB1/A1 read, O1/V1/SBE1/DBE1 result; CSB2/WEB2/A2/I2/INJ2 write;
//        SCRUB_EN scrub enable; CNT_CLR and SBE_CNT/DBE_CNT saturating error counters.
module sram_1r1w_ecc
    import ecc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              CE,
    input  logic              RST,
    input  logic              CSB1,
    input  logic [ADDR_W-1:0] A1,
    output logic [DATA_W-1:0] O1,
    output logic              V1,
    output logic              SBE1,
    output logic              DBE1,
    input  logic              CSB2,
    input  logic              WEB2,
    input  logic [ADDR_W-1:0] A2,
    input  logic [DATA_W-1:0] I2,
    input  logic [1:0]        INJ2,
    input  logic              SCRUB_EN,
    input  logic              CNT_CLR,
    output logic [CNT_W-1:0]  SBE_CNT,
    output logic [CNT_W-1:0]  DBE_CNT
);

    localparam int CW_W  = ecc_cw_width(DATA_W);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dat;
    } scrub_t;

    logic [CW_W-1:0] mem [DEPTH];

    // Accesses presented at a reset edge are discarded.
    logic rd_acc, wr_acc;
    assign rd_acc = !RST && !CSB1;
    assign wr_acc = !RST && !CSB2 && !WEB2;

    logic              s1_vld, s1_stale;
    logic [ADDR_W-1:0] s1_addr;
    logic [CW_W-1:0]   s1_cw;

    logic   scrub_vld;
    scrub_t scrub_q;
    logic   scrub_wr, scrub_load, scrub_cancel;

    logic [DATA_W-1:0] dec_dat;
    ecc_status_e       dec_status;
    logic              s1_sbe, s1_dbe;

    // A single encoder serves both the user write and the scrub write-back.
    logic [DATA_W-1:0] wr_dat;
    logic [ADDR_W-1:0] wr_addr;
    logic [CW_W-1:0]   wr_mask, enc_cw;

    assign scrub_wr = !RST && scrub_vld && !wr_acc;

    always_comb begin
        wr_dat  = scrub_q.dat;
        wr_addr = scrub_q.addr;
        wr_mask = '0;
        if (wr_acc) begin
            wr_dat     = I2;
            wr_addr    = A2;
            wr_mask[0] = INJ2[0];
            wr_mask[1] = INJ2[0] & INJ2[1];
        end
    end

    ecc_secded_enc #(.DATA_W(DATA_W)) u_enc (
        .data (wr_dat),
        .cw   (enc_cw)
    );

    // The array has no reset. The read path below samples it before this update lands,
    // so a same-edge read returns the pre-write contents.
    always_ff @(posedge CE) begin
        if (wr_acc || scrub_wr) begin
            mem[wr_addr] <= enc_cw ^ wr_mask;
        end
    end

    // Stage 1: raw codeword capture.
    always_ff @(posedge CE) begin
        if (RST) begin
            s1_vld   <= 1'b0;
            s1_stale <= 1'b0;
            s1_addr  <= '0;
            s1_cw    <= '0;
        end else begin
            s1_vld   <= rd_acc;
            // A same-edge user write means corrected old data must never be written back.
            s1_stale <= wr_acc && (A2 == A1);
            if (rd_acc) begin
                s1_addr <= A1;
                s1_cw   <= mem[A1];
            end
        end
    end

    ecc_secded_dec #(.DATA_W(DATA_W)) u_dec (
        .cw     (s1_cw),
        .data   (dec_dat),
        .status (dec_status)
    );

    assign s1_sbe = s1_vld && (dec_status == ECC_SBE);
    assign s1_dbe = s1_vld && (dec_status == ECC_DBE);

    // Stage 2: decoded result. O1 holds between reads.
    always_ff @(posedge CE) begin
        if (RST) begin
            V1   <= 1'b0;
            SBE1 <= 1'b0;
            DBE1 <= 1'b0;
            O1   <= '0;
        end else begin
            V1   <= s1_vld;
            SBE1 <= s1_sbe;
            DBE1 <= s1_dbe;
            if (s1_vld) begin
                O1 <= dec_dat;
            end
        end
    end

    // Scrub is loaded in the same cycle that SBE1 is raised. A request arriving while one is
    // pending is dropped. It is also dropped if a user write to that address has landed since
    // the read, because the corrected data would then be stale.
    assign scrub_load   = s1_sbe && SCRUB_EN && !scrub_vld && !s1_stale
                          && !(wr_acc && (A2 == s1_addr));
    assign scrub_cancel = scrub_vld && wr_acc && (A2 == scrub_q.addr);

    always_ff @(posedge CE) begin
        if (RST) begin
            scrub_vld <= 1'b0;
            scrub_q   <= '0;
        end else if (scrub_load) begin
            scrub_vld <= 1'b1;
            scrub_q   <= '{addr: s1_addr, dat: dec_dat};
        end else if (scrub_wr || scrub_cancel) begin
            scrub_vld <= 1'b0;
        end
    end

    // Counters advance together with the SBE1/DBE1 pulse. A clear on that same edge wins.
    always_ff @(posedge CE) begin
        if (RST || CNT_CLR) begin
            SBE_CNT <= '0;
            DBE_CNT <= '0;
        end else begin
            if (s1_sbe && (SBE_CNT != '1)) begin
                SBE_CNT <= SBE_CNT + CNT_W'(1);
            end
            if (s1_dbe && (DBE_CNT != '1)) begin
                DBE_CNT <= DBE_CNT + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sram_1r1w_ecc.sv
// Self-checking bench for sram_1r1w_ecc. It keeps a word-level reference memory that stores
// the data value and the error state of each word, and a two-edge read pipeline.
// It runs directed scenarios followed by randomized traffic.
module tb_sram_1r1w_ecc;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 10;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              ce = 1'b0;
    logic              rst, csb1, csb2, web2, scrub_en, cnt_clr;
    logic [ADDR_W-1:0] a1, a2;
    logic [DATA_W-1:0] i2, o1;
    logic [1:0]        inj2;
    logic              v1, sbe1, dbe1;
    logic [CNT_W-1:0]  sbe_cnt, dbe_cnt;

    sram_1r1w_ecc #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .CE       (ce),
        .RST      (rst),
        .CSB1     (csb1),
        .A1       (a1),
        .O1       (o1),
        .V1       (v1),
        .SBE1     (sbe1),
        .DBE1     (dbe1),
        .CSB2     (csb2),
        .WEB2     (web2),
        .A2       (a2),
        .I2       (i2),
        .INJ2     (inj2),
        .SCRUB_EN (scrub_en),
        .CNT_CLR  (cnt_clr),
        .SBE_CNT  (sbe_cnt),
        .DBE_CNT  (dbe_cnt)
    );

    always #5 ce = ~ce;

    // Reference state. Error kind per word: 0 clean, 1 single (correctable), 2 double.
    logic [DATA_W-1:0] m_dat [1 << ADDR_W];
    int                m_err [1 << ADDR_W];
    bit                p_vld;           // read accepted, result due at next edge
    logic [DATA_W-1:0] p_dat;
    int                p_err;
    bit                e_vld;           // expected outputs after current edge
    logic [DATA_W-1:0] e_dat, e_o1;
    int                e_err, e_sbe_cnt, e_dbe_cnt;
    int                n_checks = 0;
    int                n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Advance the reference model by one rising edge using the driven inputs, then compare
    // the DUT outputs at the following falling edge.
    task automatic tick();
        if (rst) begin
            p_vld     = 1'b0;
            e_vld     = 1'b0;
            e_o1      = '0;
            e_sbe_cnt = 0;
            e_dbe_cnt = 0;
        end else begin
            e_vld = p_vld;
            e_dat = p_dat;
            e_err = p_err;
            if (e_vld) e_o1 = e_dat;
            if (cnt_clr) begin
                e_sbe_cnt = 0;
                e_dbe_cnt = 0;
            end else if (e_vld) begin
                if (e_err == 1 && e_sbe_cnt < CNT_MAX) e_sbe_cnt++;
                if (e_err == 2 && e_dbe_cnt < CNT_MAX) e_dbe_cnt++;
            end
            p_vld = !csb1;
            if (!csb1) begin
                p_dat = m_dat[a1];
                p_err = m_err[a1];
            end
            if (!csb2 && !web2) begin
                m_dat[a2] = i2;
                m_err[a2] = (inj2 == 2'b01) ? 1 : ((inj2 == 2'b11) ? 2 : 0);
            end
        end
        @(negedge ce);
        chk("V1",      64'(v1),        64'(e_vld));
        chk("SBE1",    64'(sbe1),      64'(e_vld && e_err == 1));
        chk("DBE1",    64'(dbe1),      64'(e_vld && e_err == 2));
        chk("O1",      64'(o1),        64'(e_o1));
        chk("SBE_CNT", 64'(sbe_cnt),   64'(e_sbe_cnt));
        chk("DBE_CNT", 64'(dbe_cnt),   64'(e_dbe_cnt));
    endtask

    task automatic idle_in();
        rst     = 1'b0;
        csb1    = 1'b1;
        csb2    = 1'b1;
        web2    = 1'b1;
        a1      = '0;
        a2      = '0;
        i2      = '0;
        inj2    = 2'b00;
        cnt_clr = 1'b0;
    endtask

    task automatic do_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [1:0] inj);
        idle_in();
        csb2 = 1'b0;
        web2 = 1'b0;
        a2   = a;
        i2   = d;
        inj2 = inj;
        tick();
    endtask

    task automatic do_rd(input logic [ADDR_W-1:0] a);
        idle_in();
        csb1 = 1'b0;
        a1   = a;
        tick();
    endtask

    task automatic do_idle(input int n);
        for (int k = 0; k < n; k++) begin
            idle_in();
            tick();
        end
    endtask

    initial begin
        idle_in();
        scrub_en = 1'b0;
        rst      = 1'b1;
        tick();
        tick();

        // Plain write and read back.
        do_wr(10'h005, 32'hDEADBEEF, 2'b00);
        do_rd(10'h005);
        do_idle(2);

        // A single-bit error is corrected and counted. The scrub write-back then cleans the word.
        scrub_en = 1'b1;
        do_wr(10'h3FF, 32'h12345678, 2'b01);
        do_rd(10'h3FF);
        do_idle(3);
        m_err[10'h3FF] = 0;
        do_rd(10'h3FF);
        do_idle(2);

        // A double-bit error is flagged, counted and never scrubbed.
        do_wr(10'h010, 32'hA5A5A5A5, 2'b11);
        do_rd(10'h010);
        do_idle(3);
        do_rd(10'h010);
        do_idle(2);

        // A clear on the same edge as an error report wins.
        do_rd(10'h010);
        idle_in();
        cnt_clr = 1'b1;
        tick();
        do_idle(1);

        // A same-edge read and write return the old data.
        do_wr(10'h020, 32'h1, 2'b00);
        idle_in();
        csb1 = 1'b0; a1 = 10'h020;
        csb2 = 1'b0; web2 = 1'b0; a2 = 10'h020; i2 = 32'h2;
        tick();
        do_rd(10'h020);
        do_idle(2);

        // A pending scrub is held off by user writes and then cancelled by a write to its address.
        do_wr(10'h030, 32'h77, 2'b01);
        do_wr(10'h031, 32'h31, 2'b00);
        idle_in();
        csb1 = 1'b0; a1 = 10'h030;
        csb2 = 1'b0; web2 = 1'b0; a2 = 10'h031; i2 = 32'h131;
        tick();
        do_wr(10'h031, 32'h231, 2'b00);
        do_wr(10'h031, 32'h331, 2'b00);
        for (int k = 0; k < 3; k++) do_wr(10'h030, 32'h55, 2'b00);
        do_idle(4);
        do_rd(10'h030);
        do_rd(10'h031);
        do_idle(2);

        // Reset in the middle of back-to-back reads leaves the array intact.
        do_wr(10'h040, 32'hCAFE0040, 2'b00);
        do_wr(10'h041, 32'hCAFE0041, 2'b00);
        do_rd(10'h040);
        idle_in();
        rst = 1'b1; csb1 = 1'b0; a1 = 10'h041;
        tick();
        do_rd(10'h040);
        do_rd(10'h041);
        do_idle(2);

        // Randomized traffic over a small pre-written window, with no scrubbing.
        scrub_en = 1'b0;
        for (int k = 0; k < 16; k++) do_wr(10'h100 + 10'(k), $urandom, 2'b00);
        for (int n = 0; n < 400; n++) begin
            idle_in();
            csb1    = ($urandom_range(0, 9) < 3);
            a1      = 10'h100 + 10'($urandom_range(0, 15));
            csb2    = 1'($urandom_range(0, 1));
            web2    = ($urandom_range(0, 3) == 0);
            a2      = 10'h100 + 10'($urandom_range(0, 15));
            i2      = $urandom;
            inj2    = 2'($urandom_range(0, 3));
            cnt_clr = ($urandom_range(0, 99) == 0);
            rst     = ($urandom_range(0, 149) == 0);
            tick();
        end
        do_idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
